// File: rtl/rf_wr_arbiter_pkg.sv
// Shared widths and the buffered md-result record for the rf write-port arbiter.
package rf_wr_arbiter_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } md_res_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Generic sync FIFO, registered storage, head visible combinationally; no bypass.
// Push while full and pop while empty are ignored; the caller gates on count.
module rf_wr_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the rf write port: WB has fixed priority, md results drain from a FIFO.
// One cycle grant-to-rf_wr; md backpressured via md_ready, WB never stalled here.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_wr,
  input  logic [REG_W-1:0]    wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                md_valid,
  output logic                md_ready,
  input  logic [REG_W-1:0]    md_reg,
  input  logic [DATA_W-1:0]   md_data,
  input  logic                md_issue,
  input  logic [REG_W-1:0]    md_issue_reg,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall_req,
  output logic                rf_wr,
  output logic [REG_W-1:0]    wr_reg,
  output logic [DATA_W-1:0]   wr_data
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  md_res_t             head;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic                wb_win;
  logic                pop;
  logic                push;
  logic                blocked;
  logic [NUM_REGS-1:0] stale;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] stale_d;
  logic [SW-1:0]       starve;

  assign wb_win   = wb_wr && (wb_reg != REG_ZERO);
  assign pop      = !wb_win && !empty;
  assign blocked  = wb_win && !empty;
  assign md_ready = rst && (count < DEPTH_C);
  // r0 results complete the handshake but are never stored.
  assign push     = md_valid && md_ready && (md_reg != REG_ZERO);

  rf_wr_fifo #(
    .WIDTH ($bits(md_res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({md_reg, md_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Retire clears first so a same-cycle issue to that register re-arms it.
  always_comb begin
    busy_d  = busy;
    stale_d = stale;
    if (pop) begin
      busy_d[head.rd]  = 1'b0;
      stale_d[head.rd] = 1'b0;
    end
    if (wb_win && busy[wb_reg]) stale_d[wb_reg] = 1'b1;
    if (md_issue && (md_issue_reg != REG_ZERO)) begin
      busy_d[md_issue_reg]  = 1'b1;
      stale_d[md_issue_reg] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr     <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      busy      <= '0;
      stale     <= '0;
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      busy  <= busy_d;
      stale <= stale_d;
      if (wb_win) begin
        rf_wr   <= 1'b1;
        wr_reg  <= wb_reg;
        wr_data <= wb_data;
      end else if (pop && !stale[head.rd]) begin
        rf_wr   <= 1'b1;
        wr_reg  <= head.rd;
        wr_data <= head.data;
      end else begin
        rf_wr <= 1'b0;
      end
      if (pop)
        starve <= '0;
      else if (blocked && (starve != STARVE_LIM))
        starve <= starve + STARVE_ONE;
      stall_req <= (blocked && (starve >= STARVE_LIM)) || (full && !pop);
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: directed vector table, reset sequence, random run vs queue model.
module tb_rf_wr_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk;
  logic        rst;
  logic        wb_wr;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [31:0] busy;
  logic        stall_req;
  logic        rf_wr;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  rf_wr_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_wr        (wb_wr),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .md_valid     (md_valid),
    .md_ready     (md_ready),
    .md_reg       (md_reg),
    .md_data      (md_data),
    .md_issue     (md_issue),
    .md_issue_reg (md_issue_reg),
    .busy         (busy),
    .stall_req    (stall_req),
    .rf_wr        (rf_wr),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic [4:0] b, input logic [31:0] c,
                       input logic d, input logic [4:0] e, input logic [31:0] f,
                       input logic g, input logic [4:0] h);
    wb_wr = a; wb_reg = b; wb_data = c;
    md_valid = d; md_reg = e; md_data = f;
    md_issue = g; md_issue_reg = h;
  endtask

  typedef struct {
    logic        wb_wr;   logic [4:0] wb_reg; logic [31:0] wb_data;
    logic        md_valid; logic [4:0] md_reg; logic [31:0] md_data;
    logic        iss;     logic [4:0] iss_reg;
    logic        e_ready; logic e_rf_wr; logic [4:0] e_reg; logic [31:0] e_data;
    logic [31:0] e_busy;  logic e_stall;
  } vec_t;

  function automatic vec_t mk(logic a, logic [4:0] b, logic [31:0] c, logic d, logic [4:0] e,
                              logic [31:0] f, logic g, logic [4:0] h, logic er, logic ew,
                              logic [4:0] eg, logic [31:0] ed, logic [31:0] eb, logic es);
    vec_t v;
    v.wb_wr = a; v.wb_reg = b; v.wb_data = c;
    v.md_valid = d; v.md_reg = e; v.md_data = f;
    v.iss = g; v.iss_reg = h;
    v.e_ready = er; v.e_rf_wr = ew; v.e_reg = eg; v.e_data = ed; v.e_busy = eb; v.e_stall = es;
    return v;
  endfunction

  // Reference model: FIFO as a queue, scoreboard as bit arrays, unbounded starve count.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  bit   [31:0] m_busy, m_stale;
  int          m_starve;
  bit          m_stall, m_rf_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_busy = '0; m_stale = '0; m_starve = 0; m_stall = 0;
    m_rf_wr = 0; m_reg = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit [31:0] nb = m_busy;
    bit [31:0] ns = m_stale;
    int  n     = mq.size();
    bit  wbt   = wb_wr && (wb_reg != 0);
    bit  taken = !wbt && (n > 0);
    bit  ready = (n < DEPTH);
    ent_t h;
    m_stall = (wbt && n > 0 && m_starve >= SMAX - 1) || (n == DEPTH && !taken);
    if (taken) m_starve = 0;
    else if (wbt && n > 0) m_starve++;
    if (wbt) begin
      m_rf_wr = 1; m_reg = wb_reg; m_data = wb_data;
      if (m_busy[wb_reg]) ns[wb_reg] = 1;
    end else if (taken) begin
      h = mq.pop_front();
      if (m_stale[h.rd]) m_rf_wr = 0;
      else begin m_rf_wr = 1; m_reg = h.rd; m_data = h.data; end
      nb[h.rd] = 0; ns[h.rd] = 0;
    end else begin
      m_rf_wr = 0;
    end
    if (md_issue && md_issue_reg != 0) begin nb[md_issue_reg] = 1; ns[md_issue_reg] = 0; end
    if (md_valid && ready && md_reg != 0) begin
      h.rd = md_reg; h.data = md_data;
      mq.push_back(h);
    end
    m_busy = nb; m_stale = ns;
  endtask

  localparam int NV = 25;
  vec_t tbl[NV];

  initial begin
    // wb: wr,reg,data | md: valid,reg,data | issue,reg | exp: ready,rf_wr,reg,data,busy,stall
    tbl[0]  = mk(1,5,32'hA5,  0,0,0,        0,0,  1, 1,5,32'hA5,   32'h0,   0);
    tbl[1]  = mk(0,0,0,       0,0,0,        1,7,  1, 0,5,32'hA5,   32'h80,  0);
    tbl[2]  = mk(0,0,0,       1,7,32'h1234, 0,0,  1, 0,5,32'hA5,   32'h80,  0);
    tbl[3]  = mk(0,0,0,       0,0,0,        0,0,  1, 1,7,32'h1234, 32'h0,   0);
    tbl[4]  = mk(0,0,0,       0,0,0,        0,0,  1, 0,7,32'h1234, 32'h0,   0);
    tbl[5]  = mk(0,0,0,       0,0,0,        1,9,  1, 0,7,32'h1234, 32'h200, 0);
    tbl[6]  = mk(1,9,32'h1,   0,0,0,        0,0,  1, 1,9,32'h1,    32'h200, 0);
    tbl[7]  = mk(0,0,0,       1,9,32'h2,    0,0,  1, 0,9,32'h1,    32'h200, 0);
    tbl[8]  = mk(0,0,0,       0,0,0,        0,0,  1, 0,9,32'h1,    32'h0,   0);
    tbl[9]  = mk(0,0,0,       0,0,0,        0,0,  1, 0,9,32'h1,    32'h0,   0);
    tbl[10] = mk(0,0,0,       0,0,0,        1,3,  1, 0,9,32'h1,    32'h8,   0);
    tbl[11] = mk(0,0,0,       1,3,32'h33,   0,0,  1, 0,9,32'h1,    32'h8,   0);
    tbl[12] = mk(1,1,32'h101, 0,0,0,        0,0,  1, 1,1,32'h101,  32'h8,   0);
    tbl[13] = mk(1,1,32'h102, 0,0,0,        0,0,  1, 1,1,32'h102,  32'h8,   0);
    tbl[14] = mk(1,1,32'h103, 0,0,0,        0,0,  1, 1,1,32'h103,  32'h8,   0);
    tbl[15] = mk(1,1,32'h104, 0,0,0,        0,0,  1, 1,1,32'h104,  32'h8,   1);
    tbl[16] = mk(1,1,32'h105, 0,0,0,        0,0,  1, 1,1,32'h105,  32'h8,   1);
    tbl[17] = mk(1,1,32'h106, 0,0,0,        0,0,  1, 1,1,32'h106,  32'h8,   1);
    tbl[18] = mk(0,0,0,       0,0,0,        0,0,  1, 1,3,32'h33,   32'h0,   0);
    tbl[19] = mk(1,2,32'h200, 1,4,32'h44,   0,0,  1, 1,2,32'h200,  32'h0,   0);
    tbl[20] = mk(1,2,32'h201, 1,6,32'h66,   0,0,  1, 1,2,32'h201,  32'h0,   0);
    tbl[21] = mk(1,2,32'h202, 1,8,32'h88,   0,0,  0, 1,2,32'h202,  32'h0,   1);
    tbl[22] = mk(1,0,32'hDEAD,0,0,0,        0,0,  0, 1,4,32'h44,   32'h0,   0);
    tbl[23] = mk(0,0,0,       1,0,32'hBEEF, 1,6,  1, 1,6,32'h66,   32'h40,  0);
    tbl[24] = mk(0,0,0,       0,0,0,        1,0,  1, 0,6,32'h66,   32'h40,  0);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset rf_wr", {31'b0, rf_wr}, 32'h0);
    check("reset wr_reg", {27'b0, wr_reg}, 32'h0);
    check("reset wr_data", wr_data, 32'h0);
    check("reset busy", busy, 32'h0);
    check("reset stall_req", {31'b0, stall_req}, 32'h0);
    check("reset md_ready", {31'b0, md_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post-reset md_ready", {31'b0, md_ready}, 32'h1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].wb_wr, tbl[i].wb_reg, tbl[i].wb_data, tbl[i].md_valid, tbl[i].md_reg,
            tbl[i].md_data, tbl[i].iss, tbl[i].iss_reg);
      check($sformatf("v%0d md_ready", i), {31'b0, md_ready}, {31'b0, tbl[i].e_ready});
      @(posedge clk); #1;
      check($sformatf("v%0d rf_wr", i), {31'b0, rf_wr}, {31'b0, tbl[i].e_rf_wr});
      check($sformatf("v%0d wr_reg", i), {27'b0, wr_reg}, {27'b0, tbl[i].e_reg});
      check($sformatf("v%0d wr_data", i), wr_data, tbl[i].e_data);
      check($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("v%0d stall_req", i), {31'b0, stall_req}, {31'b0, tbl[i].e_stall});
    end

    // Fill the FIFO behind a busy WB with two busy registers, then reset mid-cycle.
    drive(1, 1, 32'h1, 1, 10, 32'hA0, 1, 10);
    @(posedge clk); #1;
    drive(1, 1, 32'h2, 1, 11, 32'hB0, 1, 11);
    @(posedge clk); #1;
    drive(1, 1, 32'h3, 0, 0, 0, 0, 0);
    check("fill md_ready", {31'b0, md_ready}, 32'h0);
    check("fill busy", busy, 32'h0000_0C40);
    #2;
    rst = 1'b0;
    #1;
    check("async rf_wr", {31'b0, rf_wr}, 32'h0);
    check("async wr_reg", {27'b0, wr_reg}, 32'h0);
    check("async wr_data", wr_data, 32'h0);
    check("async busy", busy, 32'h0);
    check("async stall_req", {31'b0, stall_req}, 32'h0);
    check("async md_ready", {31'b0, md_ready}, 32'h0);
    @(posedge clk); #1;
    check("held md_ready", {31'b0, md_ready}, 32'h0);
    check("held rf_wr", {31'b0, rf_wr}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("release md_ready", {31'b0, md_ready}, 32'h1);
    @(posedge clk); #1;
    check("drained rf_wr", {31'b0, rf_wr}, 32'h0);
    check("drained busy", busy, 32'h0);
    check("drained stall_req", {31'b0, stall_req}, 32'h0);
    model_reset();

    for (int c = 0; c < 800; c++) begin
      int wb_pct = ((c / 40) % 2 == 1) ? 92 : 45;
      int r = $urandom_range(0, 7);
      drive($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 3) == 0) && !m_busy[r], 5'(r));
      check($sformatf("r%0d md_ready", c), {31'b0, md_ready}, {31'b0, mq.size() < DEPTH});
      model_step();
      @(posedge clk); #1;
      check($sformatf("r%0d rf_wr", c), {31'b0, rf_wr}, {31'b0, m_rf_wr});
      check($sformatf("r%0d wr_reg", c), {27'b0, wr_reg}, {27'b0, m_reg});
      check($sformatf("r%0d wr_data", c), wr_data, m_data);
      check($sformatf("r%0d busy", c), busy, m_busy);
      check($sformatf("r%0d stall_req", c), {31'b0, stall_req}, {31'b0, m_stall});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
